// File: rtl/adc_sar_frontend_if.sv
// rtl/adc_sar_frontend_if.sv - controller-side bundle of the SAR ADC front end
// Controller drives power-down, channel select and the per-channel sample values.
interface adc_sar_frontend_if;
   logic       adc_pd_i;
   logic [1:0] adc_chn_sel_i;
   logic [9:0] chn0_sample_i;
   logic [9:0] chn1_sample_i;
   logic [9:0] adc_d_o;
   logic       adc_d_val_o;
   logic       illegal_sel_o;
   logic [7:0] conv_cnt_o;

   modport master (
      output adc_pd_i,
      output adc_chn_sel_i,
      output chn0_sample_i,
      output chn1_sample_i,
      input  adc_d_o,
      input  adc_d_val_o,
      input  illegal_sel_o,
      input  conv_cnt_o
   );

   modport slave (
      input  adc_pd_i,
      input  adc_chn_sel_i,
      input  chn0_sample_i,
      input  chn1_sample_i,
      output adc_d_o,
      output adc_d_val_o,
      output illegal_sel_o,
      output conv_cnt_o
   );
endinterface

// File: rtl/adc_sar_frontend.sv
// rtl/adc_sar_frontend.sv - SAR ADC front-end sequencer (power-up, conversion, result hold)
// All outputs are registered; power-down outranks every other input in every state.
module adc_sar_frontend #(
   parameter int unsigned PwrUpCycles = 3,
   parameter int unsigned ConvCycles  = 4
) (
   input logic              clk_aon_i,
   input logic              rst_aon_ni,
   adc_sar_frontend_if.slave bus
);

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_PWRUP = 3'd1,
      ST_IDLE  = 3'd2,
      ST_CONV  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_CH0  = 2'b01;
   localparam logic [1:0] SEL_CH1  = 2'b10;
   localparam logic [1:0] SEL_ILL  = 2'b11;

   localparam logic [3:0] PWR_LOAD  = 4'(PwrUpCycles - 1);
   localparam logic [3:0] CONV_LOAD = 4'(ConvCycles - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] chn_q, chn_d;
   logic [9:0] smp_q, smp_d;
   logic [9:0] data_q, data_d;
   logic       val_q, val_d;
   logic       ill_q, ill_d;
   logic [7:0] conv_cnt_q, conv_cnt_d;

   logic [1:0] sel;
   logic       sel_legal;
   logic [9:0] sel_smp;

   assign sel       = bus.adc_chn_sel_i;
   assign sel_legal = (sel == SEL_CH0) || (sel == SEL_CH1);
   assign sel_smp   = (sel == SEL_CH1) ? bus.chn1_sample_i : bus.chn0_sample_i;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      chn_d      = chn_q;
      smp_d      = smp_q;
      val_d      = 1'b0;
      ill_d      = 1'b0;
      conv_cnt_d = conv_cnt_q;

      if (bus.adc_pd_i) begin
         state_d = ST_OFF;
         cnt_d   = 4'd0;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               state_d = ST_PWRUP;
               cnt_d   = PWR_LOAD;
            end
            ST_PWRUP: begin
               if (cnt_q == 4'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            ST_IDLE: begin
               if (sel_legal) begin
                  state_d = ST_CONV;
                  chn_d   = sel;
                  smp_d   = sel_smp;
                  cnt_d   = CONV_LOAD;
               end else if (sel == SEL_ILL) begin
                  ill_d = 1'b1;
               end
            end
            ST_CONV: begin
               if (sel == SEL_NONE) begin
                  state_d = ST_IDLE;
               end else if (sel == SEL_ILL) begin
                  state_d = ST_IDLE;
                  ill_d   = 1'b1;
               end else if (sel != chn_q) begin
                  // A different channel restarts the conversion on the new input.
                  chn_d = sel;
                  smp_d = sel_smp;
                  cnt_d = CONV_LOAD;
               end else if (cnt_q == 4'd0) begin
                  state_d    = ST_DONE;
                  conv_cnt_d = conv_cnt_q + 8'd1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               if (sel == chn_q) begin
                  val_d = 1'b1;
               end else if (sel == SEL_NONE) begin
                  state_d = ST_IDLE;
               end else if (sel == SEL_ILL) begin
                  state_d = ST_IDLE;
                  ill_d   = 1'b1;
               end else begin
                  state_d = ST_CONV;
                  chn_d   = sel;
                  smp_d   = sel_smp;
                  cnt_d   = CONV_LOAD;
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = 4'd0;
            end
         endcase
      end

      data_d = val_d ? smp_q : 10'd0;
   end

   always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
      if (!rst_aon_ni) begin
         state_q    <= ST_OFF;
         cnt_q      <= 4'd0;
         chn_q      <= SEL_NONE;
         smp_q      <= 10'd0;
         data_q     <= 10'd0;
         val_q      <= 1'b0;
         ill_q      <= 1'b0;
         conv_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         chn_q      <= chn_d;
         smp_q      <= smp_d;
         data_q     <= data_d;
         val_q      <= val_d;
         ill_q      <= ill_d;
         conv_cnt_q <= conv_cnt_d;
      end
   end

   assign bus.adc_d_o       = data_q;
   assign bus.adc_d_val_o   = val_q;
   assign bus.illegal_sel_o = ill_q;
   assign bus.conv_cnt_o    = conv_cnt_q;

endmodule

// File: tb/tb_adc_sar_frontend.sv
// tb/tb_adc_sar_frontend.sv - scoreboard bench for adc_sar_frontend
// Expected results are queued with their due cycle when a select is driven.
module tb_adc_sar_frontend;

   localparam int PWR  = 3;
   localparam int CONV = 4;

   logic clk;
   logic rst_n;

   adc_sar_frontend_if bus();

   adc_sar_frontend #(.PwrUpCycles(PWR), .ConvCycles(CONV)) dut (
      .clk_aon_i  (clk),
      .rst_aon_ni (rst_n),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] data;
      logic [7:0] cnt;
      int         due;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         val_rise = 0;
   int         ill_seen = 0;
   logic       val_prev = 1'b0;
   logic [7:0] exp_cnt  = 8'd0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.adc_d_val_o && !val_prev) begin
         val_rise++;
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(bus.adc_d_val_o), 32'd0);
         end else begin
            e = sb.pop_front();
            check("sb_data", 32'(bus.adc_d_o), 32'(e.data));
            check("sb_conv_cnt", 32'(bus.conv_cnt_o), 32'(e.cnt));
            check("sb_latency", 32'(cyc), 32'(e.due));
         end
      end
      if (!bus.adc_d_val_o) check("data_zero_when_invalid", 32'(bus.adc_d_o), 32'd0);
      if (bus.illegal_sel_o) ill_seen++;
      val_prev = bus.adc_d_val_o;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [9:0] data, input int offset);
      exp_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.data = data;
      e.cnt  = exp_cnt;
      e.due  = cyc + offset;
      sb.push_back(e);
   endtask

   // Valid only when the select is acted on at the very next edge (IDLE or DONE).
   task automatic start_conv(input logic [1:0] sel, input logic [9:0] smp);
      bus.adc_chn_sel_i = sel;
      if (sel == 2'b10) bus.chn1_sample_i = smp;
      else              bus.chn0_sample_i = smp;
      push_exp(smp, 1 + CONV + 1);
   endtask

   task automatic wait_sb(input int max_cycles);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         tick(1);
         n++;
      end
      if (sb.size() != 0) begin
         check("sb_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      int base;
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int ill0;
      int rise0;
      rst_n = 1'b0;
      bus.adc_pd_i      = 1'b1;
      bus.adc_chn_sel_i = 2'b00;
      bus.chn0_sample_i = 10'd0;
      bus.chn1_sample_i = 10'd0;
      tick(3);
      check("rst_val", 32'(bus.adc_d_val_o), 32'd0);
      check("rst_data", 32'(bus.adc_d_o), 32'd0);
      check("rst_ill", 32'(bus.illegal_sel_o), 32'd0);
      check("rst_cnt", 32'(bus.conv_cnt_o), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Power up with ch0 already selected: latched on the first IDLE edge.
      bus.adc_pd_i      = 1'b0;
      bus.adc_chn_sel_i = 2'b01;
      bus.chn0_sample_i = 10'h007;
      push_exp(10'h007, 1 + PWR + 1 + CONV + 1);
      wait_sb(30);
      tick(2);
      check("done_hold_val", 32'(bus.adc_d_val_o), 32'd1);
      check("done_hold_data", 32'(bus.adc_d_o), 32'h007);
      bus.chn0_sample_i = 10'h155;
      tick(1);
      check("done_ignores_sample", 32'(bus.adc_d_o), 32'h007);

      // Switch to ch1 from DONE; a post-latch sample change must not leak through.
      start_conv(2'b10, 10'h3FF);
      tick(1);
      check("switch_val_low", 32'(bus.adc_d_val_o), 32'd0);
      tick(1);
      bus.chn1_sample_i = 10'h001;
      wait_sb(20);

      // Deselect, then power down two edges into a conversion.
      bus.adc_chn_sel_i = 2'b00;
      tick(1);
      check("deselect_val_low", 32'(bus.adc_d_val_o), 32'd0);
      tick(1);
      rise0 = val_rise;
      bus.adc_chn_sel_i = 2'b01;
      bus.chn0_sample_i = 10'h0AA;
      tick(2);
      bus.adc_pd_i = 1'b1;
      tick(8);
      check("pd_abort_no_valid", 32'(val_rise - rise0), 32'd0);
      check("pd_abort_cnt", 32'(bus.conv_cnt_o), 32'(exp_cnt));
      bus.adc_pd_i = 1'b0;
      push_exp(10'h0AA, 1 + PWR + 1 + CONV + 1);
      wait_sb(30);

      // Illegal select in IDLE pulses once per sampled edge.
      bus.adc_chn_sel_i = 2'b00;
      tick(2);
      ill0 = ill_seen;
      bus.adc_chn_sel_i = 2'b11;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("illegal_val_low", 32'(bus.adc_d_val_o), 32'd0);
      end
      bus.adc_chn_sel_i = 2'b00;
      tick(2);
      check("illegal_pulses_idle", 32'(ill_seen - ill0), 32'd3);

      // Illegal select during PWRUP is ignored.
      bus.adc_pd_i = 1'b1;
      tick(2);
      ill0 = ill_seen;
      bus.adc_pd_i      = 1'b0;
      bus.adc_chn_sel_i = 2'b11;
      tick(3);
      bus.adc_chn_sel_i = 2'b00;
      tick(3);
      check("illegal_pulses_pwrup", 32'(ill_seen - ill0), 32'd0);

      // Relatch mid-conversion: only the second channel completes.
      bus.adc_chn_sel_i = 2'b01;
      bus.chn0_sample_i = 10'h050;
      tick(2);
      start_conv(2'b10, 10'h2A0);
      wait_sb(20);
      start_conv(2'b01, 10'h123);
      wait_sb(20);

      // Asynchronous reset in the middle of a cycle while in DONE.
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_val", 32'(bus.adc_d_val_o), 32'd0);
      check("async_rst_data", 32'(bus.adc_d_o), 32'd0);
      check("async_rst_cnt", 32'(bus.conv_cnt_o), 32'd0);
      tick(1);
      exp_cnt = 8'd0;
      bus.adc_chn_sel_i = 2'b00;
      rst_n = 1'b1;
      tick(1 + PWR + 2);

      // 256 back-to-back ch0 conversions wrap the counter to 0.
      for (int i = 0; i < 256; i++) begin
         start_conv(2'b01, 10'((i * 37 + 5) & 10'h3FF));
         wait_sb(20);
         bus.adc_chn_sel_i = 2'b00;
         tick(1);
      end
      tick(2);
      check("wrap_cnt", 32'(bus.conv_cnt_o), 32'd0);
      check("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
